// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings for the MEM-stage access engine
package mem_access_unit_pkg;
   localparam int DW_DEFAULT = 8;
   localparam logic [1:0] MTR_ALU = 2'b00;
   localparam logic [1:0] MTR_MEM = 2'b01;
   localparam logic [1:0] MTR_IO  = 2'b10;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage engine for loads/stores, call/interrupt pushes, RET pops and OUT writes
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DW      = DW_DEFAULT,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] pc_plus1,
   input  logic [DW-1:0] Rd2,
   input  logic [DW-1:0] ALU_res,
   input  logic [DW-1:0] FW_value,
   input  logic [DW-1:0] IP,
   input  logic          MemWrite,
   input  logic [1:0]    MemToReg,
   input  logic          RegWrite,
   input  logic [1:0]    RegDistidx,
   input  logic          IO_Write,
   input  logic          isCall,
   input  logic          int_signal,
   input  logic          isNotRet,
   input  logic [DW-1:0] io_in,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] io_out,
   output logic          wb_valid,
   output logic          wb_RegWrite,
   output logic [1:0]    wb_RegDistidx,
   output logic [DW-1:0] wb_data,
   output logic          ret_valid,
   output logic [DW-1:0] ret_target,
   output logic          mem_err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          needs_mem, single, accept, done, abort;
   logic          lat_rw, lat_int, lat_ret;
   logic [1:0]    lat_idx;

   assign stall = (state != IDLE);

   // decode the live instruction and pick the next state
   always_comb begin
      needs_mem = MemWrite | isCall | int_signal | (MemToReg == MTR_MEM) | !isNotRet;
      single    = (state == IDLE) & in_valid & !needs_mem;
      accept    = (state == IDLE) & in_valid & needs_mem;
      done      = (state == WAIT) & mem_ready;
      abort     = (state == WAIT) & !mem_ready & (cnt == CW'(TIMEOUT));
      state_nxt = accept ? WAIT : (done | abort) ? IDLE : state;
   end

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   // memory port, latched instruction fields and wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cnt       <= '0;
         lat_rw    <= 1'b0;
         lat_int   <= 1'b0;
         lat_ret   <= 1'b0;
         lat_idx   <= '0;
      end else if (accept) begin
         mem_req   <= 1'b1;
         mem_we    <= MemWrite | isCall | int_signal;
         mem_addr  <= ALU_res;
         mem_wdata <= isCall ? pc_plus1 : int_signal ? IP : FW_value;
         cnt       <= '0;
         lat_rw    <= RegWrite;
         lat_int   <= int_signal;
         lat_ret   <= !isNotRet;
         lat_idx   <= RegDistidx;
      end else if (done | abort) begin
         mem_req   <= 1'b0;
      end else if (state == WAIT) begin
         cnt       <= cnt + CW'(1);
      end
   end

   // OUT-port register, loaded when an OUT instruction is accepted
   always_ff @(posedge clk or posedge rst)
      if (rst)                                  io_out <= '0;
      else if ((state == IDLE) & in_valid & IO_Write) io_out <= Rd2;

   // MEM/WB results, return redirect and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid      <= 1'b0;
         wb_RegWrite   <= 1'b0;
         wb_RegDistidx <= '0;
         wb_data       <= '0;
         ret_valid     <= 1'b0;
         ret_target    <= '0;
         mem_err       <= 1'b0;
      end else begin
         wb_valid    <= single | done | abort;
         wb_RegWrite <= single ? RegWrite : done ? (lat_rw & !lat_int) : 1'b0;
         ret_valid   <= done & !mem_we & lat_ret;
         if (single) begin
            wb_RegDistidx <= RegDistidx;
            wb_data       <= (MemToReg == MTR_IO) ? io_in : ALU_res;
         end
         if (done | abort) wb_RegDistidx <= lat_idx;
         if (done) wb_data <= mem_we ? mem_addr : mem_rdata;
         if (done & !mem_we & lat_ret) ret_target <= mem_rdata;
         if (abort) mem_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus checked against a transaction-level model every cycle
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;
   localparam int TO = 15;

   logic       clk = 1'b0, rst = 1'b0;
   logic       in_valid = 0, MemWrite = 0, RegWrite = 0, IO_Write = 0, isCall = 0, int_signal = 0;
   logic       isNotRet = 1, mem_ready = 0;
   logic [1:0] MemToReg = 0, RegDistidx = 0;
   logic [7:0] pc_plus1 = 0, Rd2 = 0, ALU_res = 0, FW_value = 0, IP = 0, io_in = 0, mem_rdata = 0;
   logic       stall, mem_req, mem_we, wb_valid, wb_RegWrite, ret_valid, mem_err;
   logic [1:0] wb_RegDistidx;
   logic [7:0] mem_addr, mem_wdata, io_out, wb_data, ret_target;

   mem_access_unit #(.DW(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc_plus1(pc_plus1), .Rd2(Rd2),
      .ALU_res(ALU_res), .FW_value(FW_value), .IP(IP), .MemWrite(MemWrite),
      .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDistidx(RegDistidx),
      .IO_Write(IO_Write), .isCall(isCall), .int_signal(int_signal), .isNotRet(isNotRet),
      .io_in(io_in), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .io_out(io_out), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
      .wb_RegDistidx(wb_RegDistidx), .wb_data(wb_data), .ret_valid(ret_valid),
      .ret_target(ret_target), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // One outstanding transaction at most; m_cyc is the 1-based index of the
   // current waiting cycle, and the transaction is abandoned in cycle TO+1.
   logic       m_busy = 0, m_we = 0, m_req = 0, m_wbv = 0, m_wbrw = 0, m_rv = 0, m_err = 0, m_dchk = 0;
   logic       t_rw = 0, t_int = 0, t_ret = 0;
   logic [1:0] t_idx = 0, m_idx = 0;
   logic [7:0] m_addr = 0, m_wdata = 0, m_io = 0, m_wbd = 0, m_rt = 0;
   int         m_cyc = 0;
   logic       want_mem;
   assign want_mem = MemWrite | isCall | int_signal | (MemToReg == MTR_MEM) | !isNotRet;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_we <= 0; m_req <= 0; m_wbv <= 0; m_wbrw <= 0; m_rv <= 0; m_err <= 0;
         m_dchk <= 0; m_idx <= 0; m_addr <= 0; m_wdata <= 0; m_io <= 0; m_wbd <= 0; m_rt <= 0;
      end else begin
         m_wbv <= 0; m_wbrw <= 0; m_rv <= 0; m_dchk <= 0;
         if (!m_busy) begin
            if (in_valid && IO_Write) m_io <= Rd2;
            if (in_valid && !want_mem) begin
               m_wbv <= 1; m_wbrw <= RegWrite; m_idx <= RegDistidx; m_dchk <= 1;
               m_wbd <= (MemToReg == MTR_IO) ? io_in : ALU_res;
            end else if (in_valid) begin
               m_busy <= 1; m_req <= 1; m_cyc <= 1;
               m_we <= MemWrite | isCall | int_signal;
               m_addr <= ALU_res;
               m_wdata <= isCall ? pc_plus1 : (int_signal ? IP : FW_value);
               t_rw <= RegWrite; t_int <= int_signal; t_ret <= !isNotRet; t_idx <= RegDistidx;
            end
         end else if (mem_ready) begin
            m_busy <= 0; m_req <= 0; m_wbv <= 1; m_wbrw <= t_rw && !t_int; m_idx <= t_idx;
            if (!m_we) begin
               m_wbd <= mem_rdata; m_dchk <= 1;
               if (t_ret) begin m_rv <= 1; m_rt <= mem_rdata; end
            end
         end else if (m_cyc == TO + 1) begin
            m_busy <= 0; m_req <= 0; m_err <= 1; m_wbv <= 1; m_idx <= t_idx;
         end else begin
            m_cyc <= m_cyc + 1;
         end
      end
   end

   // compare DUT against the model on every falling edge
   int stall_run = 0;
   always @(negedge clk) begin
      if (stall) stall_run <= stall_run + 1;
      chk("stall", stall, m_busy);
      chk("mem_req", mem_req, m_req);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("io_out", io_out, m_io);
      chk("wb_valid", wb_valid, m_wbv);
      chk("wb_RegWrite", wb_RegWrite, m_wbrw);
      chk("ret_valid", ret_valid, m_rv);
      chk("ret_target", ret_target, m_rt);
      chk("mem_err", mem_err, m_err);
      if (m_wbv) chk("wb_RegDistidx", wb_RegDistidx, m_idx);
      if (m_wbv && m_dchk) chk("wb_data", wb_data, m_wbd);
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic mw, rw, iow, call, intr, nret;
      logic [1:0] mtr, idx;
      logic [7:0] alu, fw, pc1, ip, rd2, io;
   } ins_t;

   function automatic ins_t nop();
      ins_t i;
      i.mw = 0; i.rw = 0; i.iow = 0; i.call = 0; i.intr = 0; i.nret = 1;
      i.mtr = MTR_ALU; i.idx = 0;
      i.alu = 0; i.fw = 0; i.pc1 = 0; i.ip = 0; i.rd2 = 0; i.io = 0;
      return i;
   endfunction

   // present one instruction for one accepting edge, then scramble the bus
   task automatic issue(input ins_t i);
      @(posedge clk); #2;
      in_valid = 1; MemWrite = i.mw; RegWrite = i.rw; IO_Write = i.iow; isCall = i.call;
      int_signal = i.intr; isNotRet = i.nret; MemToReg = i.mtr; RegDistidx = i.idx;
      ALU_res = i.alu; FW_value = i.fw; pc_plus1 = i.pc1; IP = i.ip; Rd2 = i.rd2; io_in = i.io;
      @(posedge clk); #2;
      in_valid = 0; MemWrite = 0; RegWrite = 1; IO_Write = 0; isCall = 0; int_signal = 0;
      isNotRet = 1; MemToReg = MTR_ALU; RegDistidx = 3;
      ALU_res = 8'hEE; FW_value = 8'hEE; pc_plus1 = 8'hEE; IP = 8'hEE; Rd2 = 8'hEE; io_in = 8'hEE;
   endtask

   // hold off n cycles, then complete with data
   task automatic respond(input int n, input logic [7:0] d);
      repeat (n) @(posedge clk);
      #2 mem_ready = 1; mem_rdata = d;
      @(posedge clk);
      #2 mem_ready = 0; mem_rdata = 8'h5C;
   endtask

   initial begin
      ins_t t;
      int s0;
      #1 rst = 1;
      @(posedge clk); #3;
      chk("reset stall", stall, 0);
      chk("reset mem_req", mem_req, 0);
      chk("reset wb_valid", wb_valid, 0);
      @(posedge clk); #2 rst = 0;

      // ADD, single cycle
      t = nop(); t.alu = 8'h3C; t.rw = 1; t.idx = 2;
      issue(t); #1;
      chk("add wb_valid", wb_valid, 1);
      chk("add wb_data", wb_data, 8'h3C);
      chk("add stall", stall, 0);

      // load with three non-ready cycles
      t = nop(); t.mtr = MTR_MEM; t.alu = 8'h10; t.rw = 1; t.idx = 1;
      s0 = stall_run;
      issue(t); #1;
      chk("ld mem_req", mem_req, 1);
      chk("ld mem_addr", mem_addr, 8'h10);
      respond(3, 8'hA5); #1;
      chk("ld wb_data", wb_data, 8'hA5);
      chk("ld wb_valid", wb_valid, 1);
      chk("ld stall cycles", stall_run - s0, 4);

      // CALL push
      t = nop(); t.call = 1; t.pc1 = 8'h21; t.alu = 8'hFE;
      issue(t); #1;
      chk("call mem_we", mem_we, 1);
      chk("call mem_addr", mem_addr, 8'hFE);
      chk("call mem_wdata", mem_wdata, 8'h21);
      respond(1, 8'h00); #1;
      chk("call wb_RegWrite", wb_RegWrite, 0);

      // interrupt push
      t = nop(); t.intr = 1; t.ip = 8'h47; t.fw = 8'h11; t.rw = 1; t.alu = 8'hFD;
      issue(t); #1;
      chk("int mem_wdata", mem_wdata, 8'h47);
      respond(2, 8'h00); #1;
      chk("int wb_RegWrite", wb_RegWrite, 0);

      // RET pop
      t = nop(); t.nret = 0; t.alu = 8'hFD;
      issue(t);
      respond(0, 8'h22); #1;
      chk("ret ret_valid", ret_valid, 1);
      chk("ret ret_target", ret_target, 8'h22);

      // plain store, then OUT, IN and MemToReg=11
      t = nop(); t.mw = 1; t.alu = 8'h30; t.fw = 8'h77;
      issue(t); #1;
      chk("st mem_wdata", mem_wdata, 8'h77);
      respond(0, 8'h00);
      t = nop(); t.iow = 1; t.rd2 = 8'h5A;
      issue(t); #1;
      chk("out io_out", io_out, 8'h5A);
      t = nop(); t.mtr = MTR_IO; t.io = 8'hC3; t.rw = 1; t.idx = 3;
      issue(t); #1;
      chk("in wb_data", wb_data, 8'hC3);
      t = nop(); t.mtr = 2'b11; t.alu = 8'h6B; t.rw = 1;
      issue(t); #1;
      chk("mtr11 wb_data", wb_data, 8'h6B);

      // stray mem_ready while idle
      @(posedge clk); #2 mem_ready = 1; mem_rdata = 8'h99;
      repeat (2) @(posedge clk);
      #2 mem_ready = 0;

      // timeout
      t = nop(); t.mtr = MTR_MEM; t.alu = 8'h44; t.rw = 1;
      issue(t); #1;
      chk("to req early", mem_req, 1);
      repeat (TO) @(posedge clk);
      #3;
      chk("to req last", mem_req, 1);
      chk("to err early", mem_err, 0);
      @(posedge clk); #3;
      chk("to req dropped", mem_req, 0);
      chk("to mem_err", mem_err, 1);
      chk("to wb_valid", wb_valid, 1);
      chk("to wb_RegWrite", wb_RegWrite, 0);

      // reset in the middle of a wait
      t = nop(); t.mtr = MTR_MEM; t.alu = 8'h55;
      issue(t); #1;
      chk("rst pre mem_req", mem_req, 1);
      rst = 1; #1;
      chk("rst mem_req", mem_req, 0);
      chk("rst stall", stall, 0);
      chk("rst mem_err", mem_err, 0);
      @(posedge clk); #2 rst = 0;

      t = nop(); t.alu = 8'h81; t.rw = 1;
      issue(t); #1;
      chk("post rst wb_data", wb_data, 8'h81);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
